// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file sequencer.
// FSM state encoding, request flag bundle, default widths.
package regfile_pkg;

    localparam int W_DEF     = 8;
    localparam int SEL_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_PULSE = 3'd1,
        S_RD_CAP   = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_REL   = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    typedef struct packed {
        logic rx;
        logic ry;
        logic wz;
    } req_flags_t;

endpackage

// File: rtl/regfile_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant updates only on accept.
// Requester 0 wins the first contention after reset.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       gnt_id
);

    logic last_grant;
    logic gnt_ok;

    assign gnt_id = (&valid) ? ~last_grant : valid[1];
    assign gnt_ok = enable & valid[gnt_id];
    assign grant  = {gnt_id, ~gnt_id} & {2{gnt_ok}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Strobe sequencer in front of the x/y/z register file, two requesters.
// Optional REGFILE_SEQ_ZERO_REG_EN: r0 reads zero and ignores writes.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_rx,
    input  logic [1:0]         req_ry,
    input  logic [1:0]         req_wz,
    input  logic [2*SEL_W-1:0] req_x_sel,
    input  logic [2*SEL_W-1:0] req_y_sel,
    input  logic [2*SEL_W-1:0] req_z_sel,
    input  logic [2*W-1:0]     req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [W-1:0]       rsp_x,
    output logic [W-1:0]       rsp_y,
    output logic               rf_x_enb,
    output logic               rf_y_enb,
    output logic               rf_z_enb,
    output logic [SEL_W-1:0]   rf_x_sel,
    output logic [SEL_W-1:0]   rf_y_sel,
    output logic [SEL_W-1:0]   rf_z_sel,
    output logic [W-1:0]       rf_z_in,
    input  logic [W-1:0]       rf_x_out,
    input  logic [W-1:0]       rf_y_out
);

    state_t     state, state_nxt;
    req_flags_t flg, new_flg;
    logic       gid, accept, idle;
    logic [SEL_W-1:0] xs, ys, zs;
    logic [W-1:0]     wd;

    assign idle   = (state == S_IDLE);
    assign accept = |(req_valid & req_ready);

    assign xs = req_x_sel[gid*SEL_W +: SEL_W];
    assign ys = req_y_sel[gid*SEL_W +: SEL_W];
    assign zs = req_z_sel[gid*SEL_W +: SEL_W];
    assign wd = req_wdata[gid*W +: W];

    rr_arbiter2 u_arb (
        .clk    (clock),
        .rst_n  (reset),
        .valid  (req_valid),
        .enable (idle),
        .accept (accept),
        .grant  (req_ready),
        .gnt_id (gid)
    );

    // Flags are filtered at accept so r0 accesses never reach a strobe.
    always_comb begin
        new_flg.rx = req_rx[gid];
        new_flg.ry = req_ry[gid];
        new_flg.wz = req_wz[gid];
`ifdef REGFILE_SEQ_ZERO_REG_EN
        if (xs == '0) new_flg.rx = 1'b0;
        if (ys == '0) new_flg.ry = 1'b0;
        if (zs == '0) new_flg.wz = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (new_flg.rx | new_flg.ry) state_nxt = S_RD_PULSE;
                    else if (new_flg.wz)         state_nxt = S_WR_PULSE;
                    else                         state_nxt = S_RESP;
                end
            end
            S_RD_PULSE: state_nxt = S_RD_CAP;
            S_RD_CAP:   state_nxt = flg.wz ? S_WR_PULSE : S_RESP;
            S_WR_PULSE: state_nxt = S_WR_REL;
            S_WR_REL:   state_nxt = S_RESP;
            S_RESP:     if (rsp_ready) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    assign rf_x_enb  = (state == S_RD_PULSE) & flg.rx;
    assign rf_y_enb  = (state == S_RD_PULSE) & flg.ry;
    assign rf_z_enb  = (state == S_WR_PULSE);
    assign rsp_valid = (state == S_RESP);

    // Selects and write data change only on accept, never under a strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            flg      <= '0;
            rf_x_sel <= '0;
            rf_y_sel <= '0;
            rf_z_sel <= '0;
            rf_z_in  <= '0;
            rsp_id   <= 1'b0;
            rsp_x    <= '0;
            rsp_y    <= '0;
        end else begin
            state <= state_nxt;
            if (idle && accept) begin
                flg      <= new_flg;
                rf_x_sel <= xs;
                rf_y_sel <= ys;
                rf_z_sel <= zs;
                rf_z_in  <= wd;
                rsp_id   <= gid;
                rsp_x    <= '0;
                rsp_y    <= '0;
            end else if (state == S_RD_CAP) begin
                rsp_x <= flg.rx ? rf_x_out : '0;
                rsp_y <= flg.ry ? rf_y_out : '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register file.
// Build with +define+REGFILE_SEQ_ZERO_REG_EN to exercise the r0 variant.
module tb_regfile_sequencer;

    localparam int W     = 8;
    localparam int SEL_W = 4;

    logic clk, rst_n;
    logic [1:0] req_valid, req_ready;
    logic [1:0] req_rx, req_ry, req_wz;
    logic [2*SEL_W-1:0] req_x_sel, req_y_sel, req_z_sel;
    logic [2*W-1:0] req_wdata;
    logic rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_x, rsp_y;
    logic rf_x_enb, rf_y_enb, rf_z_enb;
    logic [SEL_W-1:0] rf_x_sel, rf_y_sel, rf_z_sel;
    logic [W-1:0] rf_z_in, rf_x_out, rf_y_out;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sequencer #(.W(W), .SEL_W(SEL_W)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rx    (req_rx),
        .req_ry    (req_ry),
        .req_wz    (req_wz),
        .req_x_sel (req_x_sel),
        .req_y_sel (req_y_sel),
        .req_z_sel (req_z_sel),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rf_x_enb  (rf_x_enb),
        .rf_y_enb  (rf_y_enb),
        .rf_z_enb  (rf_z_enb),
        .rf_x_sel  (rf_x_sel),
        .rf_y_sel  (rf_y_sel),
        .rf_z_sel  (rf_z_sel),
        .rf_z_in   (rf_z_in),
        .rf_x_out  (rf_x_out),
        .rf_y_out  (rf_y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: write commits on the falling edge of the z strobe.
    logic [W-1:0] mem [16] = '{0: 8'h77, default: 8'h00};
    assign rf_x_out = mem[rf_x_sel];
    assign rf_y_out = mem[rf_y_sel];
    always @(negedge rf_z_enb) if (rst_n) mem[rf_z_sel] <= rf_z_in;

    int z_hi = 0;
    int x_hi = 0;
    int zsel_bad = 0;
    logic prev_zen = 1'b0;
    logic [SEL_W-1:0] prev_zsel = '0;
    always @(negedge clk) begin
        if (rf_z_enb) z_hi++;
        if (rf_x_enb) x_hi++;
        if (prev_zen && rf_z_sel !== prev_zsel) zsel_bad++;
        prev_zen  = rf_z_enb;
        prev_zsel = rf_z_sel;
    end

    task automatic set_req(input int r, input logic rx, input logic ry,
                           input logic wz, input logic [3:0] xs,
                           input logic [3:0] ys, input logic [3:0] zs,
                           input logic [7:0] wd);
        req_rx[r] = rx;
        req_ry[r] = ry;
        req_wz[r] = wz;
        req_x_sel[r*SEL_W +: SEL_W] = xs;
        req_y_sel[r*SEL_W +: SEL_W] = ys;
        req_z_sel[r*SEL_W +: SEL_W] = zs;
        req_wdata[r*W +: W] = wd;
    endtask

    // Issues one request with rsp_ready high; lat = 99 on timeout.
    task automatic do_req(input int r, output int lat, output logic [7:0] x,
                          output logic [7:0] y, output logic id);
        int n;
        lat = 99;
        x = '0;
        y = '0;
        id = 1'b0;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[r]) begin
            req_valid[r] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[r] = 1'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid) lat = n;
        x = rsp_x;
        y = rsp_y;
        id = rsp_id;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = '0;
        req_rx = '0;
        req_ry = '0;
        req_wz = '0;
        req_x_sel = '0;
        req_y_sel = '0;
        req_z_sel = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        #12;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
        end
        n_cmp++;
        if ({rf_x_enb, rf_y_enb, rf_z_enb} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_strobes got %b want 000",
                     {rf_x_enb, rf_y_enb, rf_z_enb});
        end
        n_cmp++;
        if ({rf_x_sel, rf_y_sel, rf_z_sel, rf_z_in} !== '0) begin
            n_err++;
            $display("FAIL reset_sel_data got %h want 0",
                     {rf_x_sel, rf_y_sel, rf_z_sel, rf_z_in});
        end
        n_cmp++;
        if ({rsp_x, rsp_y, rsp_id, req_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_rsp got %h want 0",
                     {rsp_x, rsp_y, rsp_id, req_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_then_read;
        int lat, zb, xb, sb;
        logic [7:0] x, y;
        logic id;
        zb = z_hi;
        sb = zsel_bad;
        set_req(0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 8'hA5);
        do_req(0, lat, x, y, id);
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL wr_latency got %0d want 3", lat);
        end
        n_cmp++;
        if (z_hi - zb !== 1) begin
            n_err++;
            $display("FAIL wr_pulse_cycles got %0d want 1", z_hi - zb);
        end
        n_cmp++;
        if (zsel_bad - sb !== 0) begin
            n_err++;
            $display("FAIL wr_zsel_stable got %0d changes want 0",
                     zsel_bad - sb);
        end
        n_cmp++;
        if (mem[3] !== 8'hA5) begin
            n_err++;
            $display("FAIL wr_mem3 got %h want a5", mem[3]);
        end
        xb = x_hi;
        set_req(1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 8'h00);
        do_req(1, lat, x, y, id);
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL rd_latency got %0d want 3", lat);
        end
        n_cmp++;
        if (x !== 8'hA5) begin
            n_err++;
            $display("FAIL rd_rsp_x got %h want a5", x);
        end
        n_cmp++;
        if (id !== 1'b1) begin
            n_err++;
            $display("FAIL rd_rsp_id got %b want 1", id);
        end
        n_cmp++;
        if (x_hi - xb !== 1) begin
            n_err++;
            $display("FAIL rd_x_pulse got %0d want 1", x_hi - xb);
        end
    endtask

    task automatic test_read_write_same;
        int lat;
        logic [7:0] x, y;
        logic id;
        set_req(1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd5, 8'h11);
        do_req(1, lat, x, y, id);
        n_cmp++;
        if (mem[5] !== 8'h11) begin
            n_err++;
            $display("FAIL rw_setup_mem5 got %h want 11", mem[5]);
        end
        set_req(0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd3, 4'd5, 8'h22);
        do_req(0, lat, x, y, id);
        n_cmp++;
        if (lat !== 5) begin
            n_err++;
            $display("FAIL rw_latency got %0d want 5", lat);
        end
        n_cmp++;
        if (x !== 8'h11) begin
            n_err++;
            $display("FAIL rw_old_value got %h want 11", x);
        end
        n_cmp++;
        if (y !== 8'hA5) begin
            n_err++;
            $display("FAIL rw_rsp_y got %h want a5", y);
        end
        n_cmp++;
        if (id !== 1'b0) begin
            n_err++;
            $display("FAIL rw_rsp_id got %b want 0", id);
        end
        set_req(1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 8'h00);
        do_req(1, lat, x, y, id);
        n_cmp++;
        if (x !== 8'h22) begin
            n_err++;
            $display("FAIL rw_new_value got %h want 22", x);
        end
        n_cmp++;
        if (y !== 8'h00) begin
            n_err++;
            $display("FAIL rw_unread_y got %h want 00", y);
        end
    endtask

    task automatic test_round_robin;
        logic g [4];
        int k, cyc;
        logic both;
        k = 0;
        cyc = 0;
        both = 1'b0;
        set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00);
        set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00);
        req_valid = 2'b11;
        #1;
        while (k < 4 && cyc < 40) begin
            if (req_ready == 2'b11) both = 1'b1;
            if (req_ready != 2'b00) begin
                g[k] = req_ready[1];
                k++;
            end
            if (k < 4) begin
                @(negedge clk);
                cyc++;
            end
        end
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (k !== 4) begin
            n_err++;
            $display("FAIL rr_grant_count got %0d want 4", k);
        end
        for (int i = 0; i < k; i++) begin
            n_cmp++;
            if (g[i] !== i[0]) begin
                n_err++;
                $display("FAIL rr_grant_%0d got %b want %b", i, g[i], i[0]);
            end
        end
        n_cmp++;
        if (both !== 1'b0) begin
            n_err++;
            $display("FAIL rr_both_ready got %b want 0", both);
        end
    endtask

    task automatic test_backpressure;
        int n;
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 8'h00);
        set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b11;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_x, req_ready} !== {1'b1, 1'b0, 8'hA5, 2'b00}) begin
                n_err++;
                $display("FAIL bp_hold_%0d got v=%b id=%b x=%h rdy=%b want v=1 id=0 x=a5 rdy=00",
                         i, rsp_valid, rsp_id, rsp_x, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release got %b want 0", rsp_valid);
        end
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL bp_next_grant got %b want 10", req_ready);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write;
        int n;
        logic seen;
        set_req(0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 8'h5A);
        req_valid = 2'b01;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = rf_z_enb;
        end
        req_valid = 2'b00;
        n_cmp++;
        if (seen !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_reach_wr got %b want 1", seen);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rf_z_enb !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_z_enb got %b want 0", rf_z_enb);
        end
        n_cmp++;
        if ({rsp_valid, rf_z_sel, rf_z_in} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs got %h want 0",
                     {rsp_valid, rf_z_sel, rf_z_in});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem[7] !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mid_no_write got %h want 00", mem[7]);
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00);
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL rst_mid_first_grant got %b want 01", req_ready);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_zero_reg;
        int lat, zb, xb;
        logic [7:0] x, y;
        logic id;
        int exp_lat;
        int exp_pulse;
        logic [7:0] exp_x;
`ifdef REGFILE_SEQ_ZERO_REG_EN
        exp_lat = 1;
        exp_pulse = 0;
        exp_x = 8'h00;
`else
        exp_lat = 3;
        exp_pulse = 1;
        exp_x = 8'hFF;
`endif
        zb = z_hi;
        set_req(0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 8'hFF);
        do_req(0, lat, x, y, id);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL r0_wr_latency got %0d want %0d", lat, exp_lat);
        end
        n_cmp++;
        if (z_hi - zb !== exp_pulse) begin
            n_err++;
            $display("FAIL r0_z_pulse got %0d want %0d", z_hi - zb, exp_pulse);
        end
        xb = x_hi;
        set_req(0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00);
        do_req(0, lat, x, y, id);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL r0_rd_latency got %0d want %0d", lat, exp_lat);
        end
        n_cmp++;
        if (x_hi - xb !== exp_pulse) begin
            n_err++;
            $display("FAIL r0_x_pulse got %0d want %0d", x_hi - xb, exp_pulse);
        end
        n_cmp++;
        if (x !== exp_x) begin
            n_err++;
            $display("FAIL r0_rsp_x got %h want %h", x, exp_x);
        end
    endtask

    initial begin
        test_reset;
        test_write_then_read;
        test_read_write_same;
        test_round_robin;
        test_backpressure;
        test_reset_mid_write;
        test_zero_reg;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
